td4_run_controller: RTL and testbench

Sequencer and program-memory owner for the TD4 core. It holds the 16×8 program store that drives the core's instruction bus from its address bus. It decides when the core advances: free-running at a divided rate, single step, or halted. It also arbitrates program-store writes from an external loader, holding the core in reset while a load is in progress.

---
 rtl/td4_run_controller.sv | 99 +++++++++
 tb/tb_td4_run_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_run_controller.sv
// TD4 run controller: owns the 16x8 program store and decides when the core
// advances (divided free-run, single step, halted) or is held in reset for a load.
module td4_run_controller #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       RUN_REQ,
    input  logic       HALT_REQ,
    input  logic       STEP_REQ,
    input  logic       LD_VALID,
    output logic       LD_READY,
    input  logic [3:0] LD_ADDR,
    input  logic [7:0] LD_DATA,
    input  logic       LD_LAST,
    input  logic [3:0] CPU_A,
    output logic [7:0] CPU_D,
    output logic       CPU_STEP,
    output logic       CPU_RST_N,
    output logic [1:0] STATE,
    output logic [7:0] STEPS
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        LOAD = 2'b11
    } runState_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    runState_t  state;
    runState_t  nextState;
    logic [7:0] divCnt;
    logic [7:0] stepCnt;
    logic       cpuRstN;
    logic       ldXfer;
    logic [7:0] mem [16];

    // Loader handshake: a beat transfers on a rising edge where LD_VALID and
    // LD_READY are both 1. LD_READY depends on state only, so the loader holds
    // its beat until it sees LD_READY=1; LD_VALID may drop between beats.
    assign ldXfer    = (state == LOAD) && LD_VALID;
    assign LD_READY  = (state == LOAD);
    assign CPU_STEP  = (state == STEP) || ((state == RUN) && (divCnt == DIV_LAST));
    assign CPU_RST_N = cpuRstN;
    assign CPU_D     = mem[CPU_A];
    assign STATE     = state;
    assign STEPS     = stepCnt;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (LD_VALID)      nextState = LOAD;
                else if (RUN_REQ)  nextState = RUN;
                else if (STEP_REQ) nextState = STEP;
            end
            RUN:  if (HALT_REQ) nextState = IDLE;
            STEP: nextState = IDLE;
            LOAD: if (ldXfer && LD_LAST) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= nextState;
    end

    // Divider only counts while staying in RUN, so every RUN entry starts at 0.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)                                   divCnt <= 8'd0;
        else if (state == RUN && nextState == RUN)  divCnt <= (divCnt == DIV_LAST) ? 8'd0 : divCnt + 8'd1;
        else                                        divCnt <= 8'd0;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)                                    stepCnt <= 8'd0;
        else if (state == IDLE && nextState == LOAD) stepCnt <= 8'd0;
        else if (CPU_STEP && stepCnt != 8'hFF)       stepCnt <= stepCnt + 8'd1;
    end

    // Core reset drops on the LOAD entry edge and releases one edge after LOAD exits.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) cpuRstN <= 1'b0;
        else      cpuRstN <= (state != LOAD) && (nextState != LOAD);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (ldXfer) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

endmodule

// File: tb/tb_td4_run_controller.sv
// Self-checking bench for td4_run_controller: randomized loads, runs and steps
// compared against a behavioural model of program store, pulse schedule and step count.
module tb_td4_run_controller;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       RUN_REQ = 1'b0;
    logic       HALT_REQ = 1'b0;
    logic       STEP_REQ = 1'b0;
    logic       LD_VALID = 1'b0;
    logic       LD_READY;
    logic [3:0] LD_ADDR = 4'd0;
    logic [7:0] LD_DATA = 8'd0;
    logic       LD_LAST = 1'b0;
    logic [3:0] CPU_A = 4'd0;
    logic [7:0] CPU_D;
    logic       CPU_STEP;
    logic       CPU_RST_N;
    logic [1:0] STATE;
    logic [7:0] STEPS;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [16];
    int         exp_steps = 0;
    logic [7:0] exp_q [$];

    td4_run_controller #(.DIV(DIV)) dut (
        .CLK(CLK), .CLR(CLR), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ), .STEP_REQ(STEP_REQ),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .LD_LAST(LD_LAST), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_STEP(CPU_STEP),
        .CPU_RST_N(CPU_RST_N), .STATE(STATE), .STEPS(STEPS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_mem(input string tag);
        logic [7:0] e;
        for (int a = 0; a < 16; a++) begin
            CPU_A = 4'(a);
            exp_q.push_back(model_mem[a]);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (CPU_D !== e) begin n_fail++; $display("FAIL %s mem[%0d] got=%h exp=%h", tag, a, CPU_D, e); end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset;
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
        exp_steps = 0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL rst_state got=%b exp=00", STATE); end
        n_checks++; if (CPU_RST_N !== 1'b0) begin n_fail++; $display("FAIL rst_cpurst got=%b exp=0", CPU_RST_N); end
        n_checks++; if (LD_READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", LD_READY); end
        n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL rst_step got=%b exp=0", CPU_STEP); end
        n_checks++; if (STEPS !== 8'd0) begin n_fail++; $display("FAIL rst_steps got=%0d exp=0", STEPS); end
        check_mem("rst");
        CLR = 1'b1;
        n_checks++; if (CPU_RST_N !== 1'b0) begin n_fail++; $display("FAIL rst_release_pre got=%b exp=0", CPU_RST_N); end
        tick;
        n_checks++; if (CPU_RST_N !== 1'b1) begin n_fail++; $display("FAIL rst_release_post got=%b exp=1", CPU_RST_N); end
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL rst_idle got=%b exp=00", STATE); end
    endtask

    // Loads nbeats beats; fixed=1 gives addr i / data 0xB0+i, else random (repeats allowed).
    task automatic do_load(input bit fixed, input int nbeats, input bit gaps);
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < nbeats; i++) begin
            a = fixed ? 4'(i) : 4'($urandom_range(0, 15));
            d = fixed ? 8'(8'hB0 + i) : 8'($urandom_range(0, 255));
            LD_ADDR = a; LD_DATA = d; LD_LAST = (i == nbeats - 1); LD_VALID = 1'b1;
            if (i == 0) begin
                n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL load_start_state got=%b exp=00", STATE); end
                n_checks++; if (LD_READY !== 1'b0) begin n_fail++; $display("FAIL load_first_ready got=%b exp=0", LD_READY); end
                tick;
                exp_steps = 0;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                LD_VALID = 1'b0;
                tick;
                n_checks++; if (STATE !== 2'b11) begin n_fail++; $display("FAIL load_gap_state got=%b exp=11", STATE); end
                LD_VALID = 1'b1;
            end
            n_checks++; if (LD_READY !== 1'b1) begin n_fail++; $display("FAIL load_ready beat%0d got=%b exp=1", i, LD_READY); end
            n_checks++; if (CPU_RST_N !== 1'b0) begin n_fail++; $display("FAIL load_cpurst beat%0d got=%b exp=0", i, CPU_RST_N); end
            tick;
            model_mem[a] = d;
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL load_end_state got=%b exp=00", STATE); end
        n_checks++; if (LD_READY !== 1'b0) begin n_fail++; $display("FAIL load_end_ready got=%b exp=0", LD_READY); end
        n_checks++; if (CPU_RST_N !== 1'b0) begin n_fail++; $display("FAIL load_end_cpurst got=%b exp=0", CPU_RST_N); end
        n_checks++; if (STEPS !== 8'(exp_steps)) begin n_fail++; $display("FAIL load_steps got=%0d exp=%0d", STEPS, exp_steps); end
        tick;
        n_checks++; if (CPU_RST_N !== 1'b1) begin n_fail++; $display("FAIL load_cpurst_release got=%b exp=1", CPU_RST_N); end
    endtask

    // Runs ncyc RUN cycles, halting in the last; pulses expected every DIV-th cycle.
    task automatic do_run(input int ncyc, input bit noise);
        logic [7:0] e;
        RUN_REQ = 1'b1;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL run_start_state got=%b exp=00", STATE); end
        tick;
        RUN_REQ = 1'b0;
        for (int k = 1; k <= ncyc; k++) exp_q.push_back((k % DIV == 0) ? 8'd1 : 8'd0);
        for (int k = 1; k <= ncyc; k++) begin
            if (k < ncyc) begin
                HALT_REQ = 1'b0;
                if (noise) begin
                    RUN_REQ = 1'($urandom_range(0, 1)); STEP_REQ = 1'($urandom_range(0, 1)); LD_VALID = 1'($urandom_range(0, 1));
                end
            end else begin
                RUN_REQ = 1'b0; STEP_REQ = 1'b0; LD_VALID = 1'b0; HALT_REQ = 1'b1;
            end
            e = exp_q.pop_front();
            n_checks++; if (STATE !== 2'b01) begin n_fail++; $display("FAIL run_state cyc%0d got=%b exp=01", k, STATE); end
            n_checks++; if (CPU_STEP !== e[0]) begin n_fail++; $display("FAIL run_pulse cyc%0d got=%b exp=%b", k, CPU_STEP, e[0]); end
            n_checks++; if (STEPS !== 8'(exp_steps)) begin n_fail++; $display("FAIL run_steps cyc%0d got=%0d exp=%0d", k, STEPS, exp_steps); end
            tick;
            if (e[0]) exp_steps = (exp_steps < 255) ? exp_steps + 1 : 255;
        end
        HALT_REQ = 1'b0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL run_halt_state got=%b exp=00", STATE); end
        n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL run_halt_pulse got=%b exp=0", CPU_STEP); end
        n_checks++; if (STEPS !== 8'(exp_steps)) begin n_fail++; $display("FAIL run_halt_steps got=%0d exp=%0d", STEPS, exp_steps); end
    endtask

    task automatic test_step(input int n);
        for (int j = 0; j < n; j++) begin
            STEP_REQ = 1'b1; HALT_REQ = 1'b1;
            n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL step_req_cycle got=%b exp=0", CPU_STEP); end
            tick;
            STEP_REQ = 1'b0; HALT_REQ = 1'($urandom_range(0, 1));
            n_checks++; if (STATE !== 2'b10) begin n_fail++; $display("FAIL step_state got=%b exp=10", STATE); end
            n_checks++; if (CPU_STEP !== 1'b1) begin n_fail++; $display("FAIL step_pulse got=%b exp=1", CPU_STEP); end
            tick;
            exp_steps = (exp_steps < 255) ? exp_steps + 1 : 255;
            HALT_REQ = 1'b0;
            n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL step_back_idle got=%b exp=00", STATE); end
            n_checks++; if (STEPS !== 8'(exp_steps)) begin n_fail++; $display("FAIL step_count got=%0d exp=%0d", STEPS, exp_steps); end
            repeat ($urandom_range(1, 3)) begin
                tick;
                n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL step_gap_pulse got=%b exp=0", CPU_STEP); end
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] a;
        logic [7:0] d;
        a = 4'($urandom_range(0, 15)); d = 8'($urandom_range(0, 255));
        LD_ADDR = a; LD_DATA = d; LD_LAST = 1'b1;
        LD_VALID = 1'b1; RUN_REQ = 1'b1; STEP_REQ = 1'b1;
        tick;
        RUN_REQ = 1'b0; STEP_REQ = 1'b0;
        exp_steps = 0;
        n_checks++; if (STATE !== 2'b11) begin n_fail++; $display("FAIL simul_state got=%b exp=11", STATE); end
        n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL simul_pulse got=%b exp=0", CPU_STEP); end
        n_checks++; if (LD_READY !== 1'b1) begin n_fail++; $display("FAIL simul_ready got=%b exp=1", LD_READY); end
        tick;
        model_mem[a] = d;
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL simul_end_state got=%b exp=00", STATE); end
        n_checks++; if (STEPS !== 8'd0) begin n_fail++; $display("FAIL simul_steps got=%0d exp=0", STEPS); end
        tick;
        check_mem("simul");
        do_run(300 * DIV, 1'b1);
        n_checks++; if (STEPS !== 8'd255) begin n_fail++; $display("FAIL steps_saturate got=%0d exp=255", STEPS); end
    endtask

    task automatic test_clr_mid_run;
        RUN_REQ = 1'b1;
        tick;
        RUN_REQ = 1'b0;
        repeat (DIV - 1) tick;
        #2 CLR = 1'b0;
        #1;
        exp_steps = 0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL clr_run_state got=%b exp=00", STATE); end
        n_checks++; if (CPU_STEP !== 1'b0) begin n_fail++; $display("FAIL clr_run_pulse got=%b exp=0", CPU_STEP); end
        n_checks++; if (STEPS !== 8'd0) begin n_fail++; $display("FAIL clr_run_steps got=%0d exp=0", STEPS); end
        for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
        @(negedge CLK);
        CLR = 1'b1;
        tick;
    endtask

    task automatic test_clr_mid_load;
        LD_VALID = 1'b1; LD_LAST = 1'b0;
        LD_ADDR = 4'($urandom_range(0, 15)); LD_DATA = 8'($urandom_range(1, 255));
        tick;
        for (int i = 0; i < 5; i++) begin
            LD_ADDR = 4'(i); LD_DATA = 8'($urandom_range(1, 255));
            tick;
        end
        #2 CLR = 1'b0;
        #1;
        LD_VALID = 1'b0;
        for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
        exp_steps = 0;
        n_checks++; if (STATE !== 2'b00) begin n_fail++; $display("FAIL clr_load_state got=%b exp=00", STATE); end
        n_checks++; if (LD_READY !== 1'b0) begin n_fail++; $display("FAIL clr_load_ready got=%b exp=0", LD_READY); end
        n_checks++; if (CPU_RST_N !== 1'b0) begin n_fail++; $display("FAIL clr_load_cpurst got=%b exp=0", CPU_RST_N); end
        check_mem("clr_load");
        CLR = 1'b1;
        tick;
        n_checks++; if (CPU_RST_N !== 1'b1) begin n_fail++; $display("FAIL clr_load_release got=%b exp=1", CPU_RST_N); end
        n_checks++; if (STEPS !== 8'd0) begin n_fail++; $display("FAIL clr_load_steps got=%0d exp=0", STEPS); end
    endtask

    initial begin
        test_reset;
        do_load(1'b1, 16, 1'b0);
        check_mem("fixed_load");
        do_run(20, 1'b0);
        n_checks++; if (STEPS !== 8'd5) begin n_fail++; $display("FAIL run20_steps got=%0d exp=5", STEPS); end
        test_step(3);
        do_run($urandom_range(1, 30), 1'b1);
        for (int r = 0; r < 3; r++) begin
            do_load(1'b0, $urandom_range(1, 24), 1'b1);
            check_mem("rand_load");
            do_run($urandom_range(1, 40), 1'b1);
            test_step($urandom_range(1, 3));
        end
        test_simultaneous;
        test_clr_mid_run;
        check_mem("clr_run");
        do_load(1'b0, 8, 1'b1);
        test_clr_mid_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
